// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if
// Byte hand-off channel between the UART receiver and the echo transmitter.
//   rx_data  : received byte, held stable while rx_valid is high
//   rx_valid : rx_data holds a byte that has not been consumed yet
//   rx_ready : consumer takes rx_data in any cycle with rx_valid && rx_ready
// The master modport is the receiver side; the slave modport is the consumer.
interface uart_rx_deser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
// Oversampling 8N1 UART receiver for the echo path. RXD is synchronized into the
// clk domain, each bit cell is decided by a 2-of-3 vote around mid-cell, and
// finished bytes are handed over through the valid/ready channel.
// Ports:
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   RXD       : asynchronous serial input, idle high
//   rx        : byte channel (rx_data / rx_valid out, rx_ready in)
//   frame_err : 1-cycle pulse, stop bit voted low (byte dropped)
//   overrun   : 1-cycle pulse, good byte arrived while the previous one was unread
//   busy      : receiver is inside a frame (or waiting out a break)
module uart_rx_deser #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            RXD,
    uart_rx_deser_if.master rx,
    output logic            frame_err,
    output logic            overrun,
    output logic            busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int MID          = CLKS_PER_BIT / 2;

    localparam logic [13:0] TICK_LAST = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] TICK_A    = 14'(MID - 1);
    localparam logic [13:0] TICK_B    = 14'(MID);
    localparam logic [13:0] TICK_VOTE = 14'(MID + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // 2-of-3 majority of the three mid-cell samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic        sync1_r;
    logic        sync2_r;
    logic [1:0]  fill_r;
    logic        prev_r;
    logic [13:0] cnt_r;
    logic        samp_a_r;
    logic        samp_b_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        frame_err_r;
    logic        overrun_r;
    logic        busy_r;

    logic        rxs_s;
    logic        fall_s;
    logic        at_last_s;
    logic        at_vote_s;
    logic        maj_s;
    logic        shift_en_s;
    logic        load_s;
    logic        ovr_s;
    logic        ferr_s;

    assign rxs_s     = sync2_r;
    // prev_r only becomes 1 after a genuine high has come through the
    // synchronizer, so a line that is already low after reset is no start edge.
    assign fall_s    = prev_r & ~rxs_s;
    assign at_last_s = (cnt_r == TICK_LAST);
    assign at_vote_s = (cnt_r == TICK_VOTE);
    assign maj_s     = maj3(samp_a_r, samp_b_r, rxs_s);

    // Input synchronizer, fill tracker and start-edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            fill_r  <= 2'b00;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= RXD;
            sync2_r <= sync1_r;
            fill_r  <= {fill_r[0], 1'b1};
            prev_r  <= rxs_s & fill_r[1];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and strobes
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        load_s       = 1'b0;
        ovr_s        = 1'b0;
        ferr_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Vote mid-cell to reject glitches, but stay for the whole start
                // cell so every data cell is entered on its own boundary.
                if (at_vote_s && maj_s) begin
                    state_next_s = ST_IDLE;
                end else if (at_last_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                shift_en_s = at_vote_s;
                if (at_last_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (at_vote_s) begin
                    if (maj_s) begin
                        state_next_s = ST_IDLE;
                        // A consumer taking the old byte this cycle frees the slot.
                        if (!rx_valid_r || rx.rx_ready) begin
                            load_s = 1'b1;
                        end else begin
                            ovr_s = 1'b1;
                        end
                    end else begin
                        state_next_s = ST_BREAK;
                        ferr_s       = 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rxs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Bit-cell tick counter, restarted on every state entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 14'd0;
        end else if ((state_next_s != state_r) || (state_r == ST_IDLE)) begin
            cnt_r <= 14'd0;
        end else if (at_last_s) begin
            cnt_r <= 14'd0;
        end else begin
            cnt_r <= cnt_r + 14'd1;
        end
    end

    // Mid-cell samples, bit index and data shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_a_r  <= 1'b1;
            samp_b_r  <= 1'b1;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            if (cnt_r == TICK_A) samp_a_r <= rxs_s;
            if (cnt_r == TICK_B) samp_b_r <= rxs_s;
            if (state_r == ST_START) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == ST_DATA) && at_last_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (shift_en_s) shift_r <= {maj_s, shift_r[7:1]};
        end
    end

    // Output byte register, handshake and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (load_s) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && rx.rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            frame_err_r <= ferr_s;
            overrun_r   <= ovr_s;
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    assign rx.rx_data  = rx_data_r;
    assign rx.rx_valid = rx_valid_r;
    assign frame_err   = frame_err_r;
    assign overrun     = overrun_r;
    assign busy        = busy_r;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser. The line rate is raised so a bit cell is 32 clocks,
// keeping whole frames short while exercising the same sampling rules.
module tb_uart_rx_deser;
    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int MID      = CPB / 2;

    logic clk = 1'b0;
    logic reset_n;
    logic RXD;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_deser_if rx_if ();

    uart_rx_deser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .RXD       (RXD),
        .rx        (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, gathered at the falling edge
    logic [7:0]  got_q[$];
    int          ferr_cnt;
    int          ovr_cnt;
    int          run_len;
    int          max_run;
    int unsigned rise_cyc;
    int unsigned fall_cyc;
    logic        vprev;

    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
            if (rx_if.rx_valid && !vprev) rise_cyc = cyc;
            if (rx_if.rx_valid) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            vprev = rx_if.rx_valid;
        end else begin
            vprev   = 1'b0;
            run_len = 0;
        end
    end

    task automatic clear_obs();
        got_q.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        max_run  = 0;
        rise_cyc = 0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit cell; optional single-clock low spike at the mid-cell sample
    task automatic send_bit(input logic v, input logic spike);
        for (int j = 0; j < CPB; j++) begin
            RXD = (spike && (j == MID)) ? 1'b0 : v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic spike);
        fall_cyc = cyc;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], spike);
        send_bit(stop_v, 1'b0);
    endtask

    function automatic logic [7:0] first_got();
        return (got_q.size() > 0) ? got_q[0] : 8'hxx;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        RXD = 1'b1;
        rx_if.rx_ready = 1'b1;
        #100;
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_if.rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wait_clks(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        clear_obs();
        rx_if.rx_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_clks(4);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
        checks++; if (first_got() !== 8'h55) begin errors++; $display("FAIL single_data got %h want 55", first_got()); end
        checks++; if (max_run != 1) begin errors++; $display("FAIL single_pulse got %0d want 1", max_run); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
        // RXD falls before edge c+1; valid seen after 9.5 cells + 4 clocks of that edge
        checks++; if ((rise_cyc - fall_cyc) != (9 * CPB + MID + 5)) begin
            errors++; $display("FAIL single_latency got %0d want %0d", rise_cyc - fall_cyc, 9 * CPB + MID + 5);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        rx_if.rx_ready = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h7D, 1'b1, 1'b0);
        wait_clks(4);
        checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL b2b_overrun got %0d want 1", ovr_cnt); end
        checks++; if (rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", rx_if.rx_valid); end
        checks++; if (rx_if.rx_data !== 8'h55) begin errors++; $display("FAIL b2b_data got %h want 55", rx_if.rx_data); end
        rx_if.rx_ready = 1'b1;
        wait_clks(1);
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", rx_if.rx_valid); end
        checks++; if (first_got() !== 8'h55) begin errors++; $display("FAIL b2b_taken got %h want 55", first_got()); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL b2b_count got %0d want 1", got_q.size()); end
    endtask

    task automatic test_glitch();
        clear_obs();
        rx_if.rx_ready = 1'b1;
        RXD = 1'b0;
        wait_clks(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start got %b want 1", busy); end
        RXD = 1'b1;
        wait_clks(2 * CPB);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
        checks++; if (max_run != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", max_run); end
        checks++; if ((ferr_cnt + ovr_cnt) != 0) begin errors++; $display("FAIL glitch_flags got %0d want 0", ferr_cnt + ovr_cnt); end
    endtask

    task automatic test_frame_err();
        clear_obs();
        rx_if.rx_ready = 1'b1;
        send_frame(8'hA3, 1'b0, 1'b0);
        wait_clks(3 * CPB);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low got %b want 1", busy); end
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt); end
        checks++; if (max_run != 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", max_run); end
        RXD = 1'b1;
        wait_clks(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_high got %b want 0", busy); end
        wait_clks(CPB);
        clear_obs();
        send_frame(8'h41, 1'b1, 1'b0);
        wait_clks(4);
        checks++; if (first_got() !== 8'h41) begin errors++; $display("FAIL ferr_next got %h want 41", first_got()); end
    endtask

    task automatic test_majority();
        clear_obs();
        rx_if.rx_ready = 1'b1;
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_clks(4);
        checks++; if (first_got() !== 8'hFF) begin errors++; $display("FAIL majority got %h want ff", first_got()); end
    endtask

    // Random bytes, some with a low stop bit; good frames must come out in order
    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_ferr;
        logic [7:0] b;
        logic       bad;
        clear_obs();
        exp_ferr = 0;
        rx_if.rx_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad, 1'b0);
            if (bad) begin
                exp_ferr++;
                RXD = 1'b1;
                wait_clks(CPB);
            end else begin
                exp_q.push_back(b);
            end
            RXD = 1'b1;
            wait_clks($urandom_range(0, 8));
        end
        wait_clks(4);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        checks++; if (ferr_cnt != exp_ferr) begin errors++; $display("FAIL rand_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        clear_obs();
        rx_if.rx_ready = 1'b1;
        b = 8'h55;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
        RXD = b[4];
        wait_clks(MID);
        reset_n = 1'b0;
        RXD = 1'b1;
        wait_clks(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", rx_if.rx_data); end
        reset_n = 1'b1;
        wait_clks(2 * CPB);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_nobyte got %0d want 0", got_q.size()); end
        // Line already low when reset is released must not start a frame
        reset_n = 1'b0;
        RXD = 1'b0;
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(2 * CPB);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_lowline got %b want 0", busy); end
        RXD = 1'b1;
        wait_clks(CPB);
        send_frame(8'h7D, 1'b1, 1'b0);
        wait_clks(4);
        checks++; if (first_got() !== 8'h7D) begin errors++; $display("FAIL rst_next got %h want 7d", first_got()); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_count got %0d want 1", got_q.size()); end
    endtask

    initial begin
        vprev = 1'b0;
        run_len = 0;
        clear_obs();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_majority();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
